// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: default widths, reset vector and fetch-queue entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // One fetch-queue slot: PC is known at reservation, inst arrives with the response.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect, and decode handshake.
interface fetch_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned ILEN = riscv_pkg::ILEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_inst;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, if_ready
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order fetch buffer: slots are reserved at request time, filled in order by responses,
// and popped from the head once filled. Flush empties it in one cycle.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ILEN    = riscv_pkg::ILEN,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     reserve,
  input  entry_t                   reserve_entry,
  input  logic                     fill,
  input  logic [ILEN-1:0]          fill_inst,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pending,
  output entry_t                   head,
  output logic                     head_filled
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head_ptr, tail_ptr, fill_ptr;
  logic [CW-1:0]   count_q, filled_q;
  logic            do_res, do_fill, do_pop;

  // Filled entries form a prefix from the head, so a filled count is enough to
  // know whether the head is visible and where the next response goes.
  assign do_res      = reserve && (count_q != CW'(DEPTH));
  assign do_fill     = fill && (pending != '0);
  assign do_pop      = pop && (filled_q != '0);
  assign count       = count_q;
  assign pending     = count_q - filled_q;
  assign head        = mem[head_ptr];
  assign head_filled = (filled_q != '0);

  // Pointer, counter and storage update; flush wins over every other operation.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count_q  <= '0;
      filled_q <= '0;
    end else begin
      if (do_res) begin
        mem[tail_ptr] <= reserve_entry;
        tail_ptr      <= tail_ptr + AW'(1);
      end
      if (do_fill) begin
        mem[fill_ptr].inst   <= fill_inst;
        mem[fill_ptr].filled <= 1'b1;
        fill_ptr             <= fill_ptr + AW'(1);
      end
      if (do_pop) head_ptr <= head_ptr + AW'(1);
      count_q  <= count_q + CW'(do_res) - CW'(do_pop);
      filled_q <= filled_q + CW'(do_fill) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, request gating, redirect/flush and stale-response drop.
module fetch_unit #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter int unsigned     ILEN     = riscv_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC),
  parameter int unsigned     DEPTH    = 4
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            filled;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   drop_cnt, drop_d, inflight;
  logic [CW-1:0]   q_count, q_pending;
  entry_t          head, res_entry;
  logic            head_filled, req_fire, pop, fill, redirect;

  assign redirect           = bus.redirect_valid;
  assign bus.imem_req_valid = !rst && !redirect && (q_count < CW'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.if_valid = head_filled && head.filled && !redirect;
  assign bus.if_pc    = head_filled ? head.pc   : '0;
  assign bus.if_inst  = head_filled ? head.inst : '0;
  assign pop          = bus.if_valid && bus.if_ready;
  assign fill         = bus.imem_rsp_valid && (drop_cnt == '0) && !redirect;
  assign res_entry    = '{pc: pc_q, inst: '0, filled: 1'b0};

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ILEN    (ILEN),
    .entry_t (entry_t)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .flush         (redirect),
    .reserve       (req_fire),
    .reserve_entry (res_entry),
    .fill          (fill),
    .fill_inst     (bus.imem_rsp_data),
    .pop           (pop),
    .count         (q_count),
    .pending       (q_pending),
    .head          (head),
    .head_filled   (head_filled)
  );

  // Drop counter: on redirect it absorbs every request still outstanding (older drops
  // plus reserved-unfilled slots) minus any response consumed this same cycle.
  always_comb begin
    inflight = drop_cnt + q_pending;
    drop_d   = drop_cnt;
    if (redirect) begin
      drop_d = inflight - CW'(bus.imem_rsp_valid && (inflight != '0));
    end else if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
      drop_d = drop_cnt - CW'(1);
    end
  end

  // PC and drop-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_d;
      if (redirect)      pc_q <= bus.redirect_pc & ~XLEN'(3);
      else if (req_fire) pc_q <= pc_q + XLEN'(4);
    end
  end

  // A response with nothing to drop and nothing reserved means the memory broke protocol.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(bus.imem_rsp_valid && (drop_cnt == '0) && (q_pending == '0)));
  end

endmodule
